// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice: op encodings and default datapath width.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_EQ  = 2'b01;
  localparam logic [1:0] OP_GET = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int ALU_W = 20;

endpackage

// File: rtl/alu_ucmp.sv
// Combinational unsigned comparator: equality and greater-than-or-equal.
module alu_ucmp #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             ge
);

  assign eq = (a == b);
  assign ge = (a >= b);

endmodule

// File: rtl/alu_and_cmp_unit.sv
// Registered ALU slice: AND / EQ / unsigned GE with zero and sign status flags,
// one cycle of latency, no backpressure.
module alu_and_cmp_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             sign,
  output logic             valid_out
);

  logic             cmp_eq;
  logic             cmp_ge;
  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] c_nxt;
  logic             zero_nxt;
  logic             sign_nxt;

  alu_ucmp #(.WIDTH(WIDTH)) u_ucmp (
    .a  (a),
    .b  (b),
    .eq (cmp_eq),
    .ge (cmp_ge)
  );

  assign and_res = a & b;

  always_comb begin
    c_nxt    = '0;
    zero_nxt = 1'b0;
    sign_nxt = 1'b0;
    case (op)
      OP_AND: begin
        c_nxt    = and_res;
        zero_nxt = (and_res == '0);
      end
      OP_EQ: begin
        zero_nxt = cmp_eq;
      end
      OP_GET: begin
        zero_nxt = cmp_eq;
        sign_nxt = cmp_ge;
      end
      default: begin
        // reserved op behaves as a NOP that still produces a valid all-zero result
        c_nxt    = '0;
      end
    endcase
  end

  // rst wins over valid_in so an op in flight during reset is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= '0;
      zero      <= 1'b0;
      sign      <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        c    <= c_nxt;
        zero <= zero_nxt;
        sign <= sign_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_and_cmp_unit.sv
// Scoreboard bench for alu_and_cmp_unit: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_alu_and_cmp_unit;

  localparam int W = 20;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         zero;
  logic         sign;
  logic         valid_out;

  typedef struct {
    logic         v;
    logic [W-1:0] c;
    logic         z;
    logic         s;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  alu_and_cmp_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .zero      (zero),
    .sign      (sign),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs; the expectation is queued at the consuming edge.
  task automatic step(input logic r, input logic vi, input logic [1:0] o,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic ev, input logic [W-1:0] ec,
                      input logic ez, input logic es);
    exp_t e;
    rst      = r;
    valid_in = vi;
    op       = o;
    a        = aa;
    b        = bb;
    @(posedge clk);
    e.v = ev; e.c = ec; e.z = ez; e.s = es;
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      step_no++;
      checks++;
      if (valid_out !== e.v || c !== e.c || zero !== e.z || sign !== e.s) begin
        errors++;
        $display("FAIL step%0d: got v=%0b c=%05h z=%0b s=%0b, want v=%0b c=%05h z=%0b s=%0b",
                 step_no, valid_out, c, zero, sign, e.v, e.c, e.z, e.s);
      end
    end else if (valid_out === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_valid: got valid_out=1 c=%05h, want no output", c);
    end
  end

  initial begin
    rst = 1'b0; valid_in = 1'b0; op = 2'b00; a = '0; b = '0;
    @(posedge clk);
    #1;

    // reset held with a valid op pending
    step(1, 1, 2'b00, 20'hFFFFF, 20'hFFFFF, 0, 20'h00000, 0, 0);
    step(1, 1, 2'b00, 20'hFFFFF, 20'hFFFFF, 0, 20'h00000, 0, 0);

    // AND
    step(0, 1, 2'b00, 20'hF0F0F, 20'h0F0F0, 1, 20'h00000, 1, 0);
    step(0, 1, 2'b00, 20'hFFFFF, 20'h80001, 1, 20'h80001, 0, 0);
    // hold a nonzero result word
    step(0, 0, 2'b00, 20'h12345, 20'h00000, 0, 20'h80001, 0, 0);

    // EQ
    step(0, 1, 2'b01, 20'h12345, 20'h12345, 1, 20'h00000, 1, 0);
    step(0, 1, 2'b01, 20'h12345, 20'h12344, 1, 20'h00000, 0, 0);

    // GET
    step(0, 1, 2'b10, 20'h00010, 20'h0000F, 1, 20'h00000, 0, 1);
    step(0, 1, 2'b10, 20'h00000, 20'hFFFFF, 1, 20'h00000, 0, 0);
    step(0, 1, 2'b10, 20'hABCDE, 20'hABCDE, 1, 20'h00000, 1, 1);

    // hold flags with changed operands, then reserved op
    step(0, 0, 2'b00, 20'h00FFF, 20'h00FFF, 0, 20'h00000, 1, 1);
    step(0, 1, 2'b11, 20'hFFFFF, 20'hFFFFF, 1, 20'h00000, 0, 0);

    // back-to-back, then reset mid-stream
    step(0, 1, 2'b00, 20'h3C3C3, 20'h0FF00, 1, 20'h0C300, 0, 0);
    step(0, 1, 2'b01, 20'h55555, 20'h55555, 1, 20'h00000, 1, 0);
    step(0, 1, 2'b10, 20'hFFFFF, 20'h00001, 1, 20'h00000, 0, 1);
    step(0, 1, 2'b00, 20'hFFFFF, 20'hFFFFF, 1, 20'hFFFFF, 0, 0);
    step(1, 1, 2'b00, 20'hFFFFF, 20'hFFFFF, 0, 20'h00000, 0, 0);
    step(0, 0, 2'b10, 20'hFFFFF, 20'h00000, 0, 20'h00000, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
